// File: rtl/mul_writeback_if.sv
// ---------------------------------------------------------------------------
// mul_writeback_if
//   Bundles the signals between the multiply/ALU execute side, the register
//   file write port and the mul_writeback stage.
//
//   Modports:
//     master : execute side / register file. Drives the multiply completion,
//              the ALU writeback request and (optionally) the forwarding read
//              addresses. Observes the register-file write port, stall and
//              ovf_err.
//     slave  : the mul_writeback stage itself.
//
//   Signals:
//     mul_done, mul_RW, mul_DA, product   multiply completion (one-cycle pulse)
//     alu_RW, alu_DA, alu_data            single-cycle ALU writeback request
//     wr_en, wr_addr, wr_data             merged register-file write port
//     stall                               product still pending
//     ovf_err                             sticky: multiply arrived while busy
//
//   Optional macro MUL_WB_FWD_EN adds the operand-forwarding signals
//   rd_addr_a/rd_addr_b (in), fwd_hit_a/fwd_hit_b and fwd_data_a/fwd_data_b
//   (out).
// ---------------------------------------------------------------------------
interface mul_writeback_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic            mul_done;
  logic            mul_RW;
  logic [AW-1:0]   mul_DA;
  logic [2*DW-1:0] product;

  logic            alu_RW;
  logic [AW-1:0]   alu_DA;
  logic [DW-1:0]   alu_data;

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;

  logic            stall;
  logic            ovf_err;

`ifdef MUL_WB_FWD_EN
  logic [AW-1:0]   rd_addr_a;
  logic [AW-1:0]   rd_addr_b;
  logic            fwd_hit_a;
  logic            fwd_hit_b;
  logic [DW-1:0]   fwd_data_a;
  logic [DW-1:0]   fwd_data_b;

  modport master (
    output mul_done, mul_RW, mul_DA, product,
    output alu_RW, alu_DA, alu_data,
    output rd_addr_a, rd_addr_b,
    input  wr_en, wr_addr, wr_data, stall, ovf_err,
    input  fwd_hit_a, fwd_hit_b, fwd_data_a, fwd_data_b
  );

  modport slave (
    input  mul_done, mul_RW, mul_DA, product,
    input  alu_RW, alu_DA, alu_data,
    input  rd_addr_a, rd_addr_b,
    output wr_en, wr_addr, wr_data, stall, ovf_err,
    output fwd_hit_a, fwd_hit_b, fwd_data_a, fwd_data_b
  );
`else
  modport master (
    output mul_done, mul_RW, mul_DA, product,
    output alu_RW, alu_DA, alu_data,
    input  wr_en, wr_addr, wr_data, stall, ovf_err
  );

  modport slave (
    input  mul_done, mul_RW, mul_DA, product,
    input  alu_RW, alu_DA, alu_data,
    output wr_en, wr_addr, wr_data, stall, ovf_err
  );
`endif

endinterface

// File: rtl/mul_writeback.sv
// ---------------------------------------------------------------------------
// mul_writeback
//   Writeback stage sitting directly behind the multi-cycle multiplier.
//   When a multiply completes, the 2*DW-bit product and its destination are
//   captured; the product is then committed through the single register-file
//   write port as two DW-bit writes (low word to DA, high word to DA+1),
//   interleaved with the normal single-cycle ALU writeback stream. The ALU
//   always has priority on the port; a pending product simply waits.
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous, active-high reset
//     bus   mul_writeback_if.slave:
//             in : mul_done, mul_RW, mul_DA, product, alu_RW, alu_DA, alu_data
//             out: wr_en, wr_addr, wr_data, stall, ovf_err
//
//   Parameters:
//     DW  data word width (product is 2*DW wide)
//     AW  register address width; register 0 is hardwired zero and never
//         written.
//
//   Optional macro MUL_WB_FWD_EN: adds operand forwarding of the held
//   product words to two read ports (rd_addr_a/b -> fwd_hit_a/b,
//   fwd_data_a/b). Without the macro the forwarding logic does not exist
//   and the core behaviour is unchanged.
// ---------------------------------------------------------------------------
module mul_writeback #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input logic           clk,
  input logic           rst,
  mul_writeback_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } state_t;

  state_t        state_reg;
  logic [DW-1:0] lo_reg;
  logic [DW-1:0] hi_reg;
  logic [AW-1:0] da_lo_reg;
  logic [AW-1:0] da_hi_reg;
  logic          ovf_reg;

  // -------------------------------------------------------------------------
  // Control FSM and product holding registers.
  // The high-word destination is computed once at capture time; the add
  // wraps naturally at AW bits, so DA = 2**AW-1 sends the high word to R0,
  // where the R0 guard below suppresses it.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      lo_reg    <= '0;
      hi_reg    <= '0;
      da_lo_reg <= '0;
      da_hi_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      // A completion while a product is still pending cannot be held: it is
      // dropped and flagged; the in-flight product is left untouched.
      if (bus.mul_done && (state_reg != IDLE)) begin
        ovf_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          // Capture even when the ALU uses the port this same cycle; the
          // product's first write can only happen next cycle anyway.
          if (bus.mul_done && bus.mul_RW) begin
            lo_reg    <= bus.product[DW-1:0];
            hi_reg    <= bus.product[2*DW-1:DW];
            da_lo_reg <= bus.mul_DA;
            da_hi_reg <= bus.mul_DA + AW'(1);
            state_reg <= WR_LO;
          end
        end
        WR_LO: begin
          if (!bus.alu_RW) begin
            state_reg <= WR_HI;
          end
        end
        WR_HI: begin
          if (!bus.alu_RW) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Write-port arbitration. ALU request wins whenever present; otherwise the
  // pending product word (if any) takes the port.
  // -------------------------------------------------------------------------
  logic          sel_req;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  always_comb begin
    sel_req  = bus.alu_RW;
    sel_addr = bus.alu_DA;
    sel_data = bus.alu_data;
    case (state_reg)
      WR_LO: begin
        if (!bus.alu_RW) begin
          sel_req  = 1'b1;
          sel_addr = da_lo_reg;
          sel_data = lo_reg;
        end
      end
      WR_HI: begin
        if (!bus.alu_RW) begin
          sel_req  = 1'b1;
          sel_addr = da_hi_reg;
          sel_data = hi_reg;
        end
      end
      default: begin
      end
    endcase
  end

  // R0 is hardwired zero: a write aimed at it is squashed here, but the FSM
  // has already treated it as done. Reset also squashes the port so nothing
  // (ALU or abandoned product) is written during the reset cycle.
  assign bus.wr_en   = !rst && sel_req && (sel_addr != '0);
  assign bus.wr_addr = sel_addr;
  assign bus.wr_data = sel_data;

  assign bus.stall   = !rst && (state_reg != IDLE);
  assign bus.ovf_err = ovf_reg;

`ifdef MUL_WB_FWD_EN
  // -------------------------------------------------------------------------
  // Operand forwarding of the held product words. In WR_LO both words are
  // still unwritten; in WR_HI the low word is already in the register file,
  // so only the high-word destination may hit. Register 0 never forwards.
  // -------------------------------------------------------------------------
  logic [AW-1:0] rd_addr [2];

  assign rd_addr[0] = bus.rd_addr_a;
  assign rd_addr[1] = bus.rd_addr_b;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic          hit;
    logic [DW-1:0] data;

    always_comb begin
      hit  = 1'b0;
      data = '0;
      if (rd_addr[gi] != '0) begin
        if ((state_reg == WR_LO) && (rd_addr[gi] == da_lo_reg)) begin
          hit  = 1'b1;
          data = lo_reg;
        end else if (((state_reg == WR_LO) || (state_reg == WR_HI)) &&
                     (rd_addr[gi] == da_hi_reg)) begin
          hit  = 1'b1;
          data = hi_reg;
        end
      end
    end
  end

  assign bus.fwd_hit_a  = g_fwd[0].hit;
  assign bus.fwd_data_a = g_fwd[0].data;
  assign bus.fwd_hit_b  = g_fwd[1].hit;
  assign bus.fwd_data_b = g_fwd[1].data;
`endif

endmodule
